// File: rtl/d_egress_scheduler_pkg.sv
// Shared types and constants for the egress scheduler: source tags, arbiter
// states and the depth of the output buffer.
package d_egress_pkg;

  typedef enum logic {
    SRC_D0 = 1'b0,
    SRC_D1 = 1'b1
  } src_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SERVE_D0 = 2'd1,
    SERVE_D1 = 2'd2
  } arb_state_t;

  localparam int BUF_DEPTH = 2;

endpackage

// File: rtl/d_egress_scheduler_if.sv
// Merged output stream of the egress scheduler: tagged word with valid/ready.
interface d_egress_scheduler_if
  import d_egress_pkg::*;
#(
  parameter int DATA_WIDTH = 6
);
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  src_t                  out_src;

  modport master (output out_valid, output out_data, output out_src, input out_ready);
  modport slave  (input out_valid, input out_data, input out_src, output out_ready);
endinterface

// File: rtl/d_egress_scheduler_skid_fifo.sv
// Two-entry output buffer built as head/tail registers, so the head word
// (and therefore the stream output) comes straight from a flop.
module egress_skid_fifo
  import d_egress_pkg::*;
#(
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [1:0]       occ,
  output logic [WIDTH-1:0] head
);
  localparam logic [1:0] FULL = 2'(BUF_DEPTH);

  logic [WIDTH-1:0] tail;
  logic             pop_ok;
  logic             push_ok;

  assign pop_ok  = pop & (occ != 2'd0);
  // A push into a full buffer is only legal when the head leaves in the same cycle.
  assign push_ok = push & ((occ != FULL) | pop_ok);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ  <= 2'd0;
      head <= '0;
      tail <= '0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10: begin
          if (occ == 2'd0) head <= push_data;
          else             tail <= push_data;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          head <= tail;
          occ  <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            head <= push_data;
          end else begin
            head <= tail;
            tail <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/d_egress_scheduler.sv
// Round-robin merge of the D0/D1 destination FIFOs into one tagged stream,
// with per-source saturating delivery counters and an idle indication.
module d_egress_scheduler
  import d_egress_pkg::*;
#(
  parameter int DATA_WIDTH = 6,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  active_in,
  input  logic                  empty_fifo_D0,
  input  logic                  empty_fifo_D1,
  input  logic [DATA_WIDTH-1:0] data_out_D0,
  input  logic [DATA_WIDTH-1:0] data_out_D1,
  output logic                  D0_pop,
  output logic                  D1_pop,
  d_egress_scheduler_if.master  out_if,
  output logic [CNT_WIDTH-1:0]  cnt_D0,
  output logic [CNT_WIDTH-1:0]  cnt_D1,
  output logic                  idle_out
);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  arb_state_t          state;
  src_t                prio;
  logic                inflight_v;
  src_t                inflight_src;
  logic [1:0]          occ;
  logic [DATA_WIDTH:0] head;
  logic [DATA_WIDTH:0] push_word;
  logic [2:0]          fill_next;
  logic                drain;
  logic                space;
  logic                eligible;

  assign drain     = out_if.out_valid & out_if.out_ready;
  // Occupancy once the in-flight word lands and the current drain completes.
  assign fill_next = {1'b0, occ} + {2'b00, inflight_v} - {2'b00, drain};
  assign space     = fill_next < 3'd2;
  assign eligible  = ~reset & active_in & space & (~empty_fifo_D0 | ~empty_fifo_D1);

  always_comb begin
    state = IDLE;
    if (eligible) begin
      if (~empty_fifo_D0 & ~empty_fifo_D1) state = (prio == SRC_D1) ? SERVE_D1 : SERVE_D0;
      else if (~empty_fifo_D0)             state = SERVE_D0;
      else                                 state = SERVE_D1;
    end
  end

  assign D0_pop = (state == SERVE_D0);
  assign D1_pop = (state == SERVE_D1);

  // Stage boundary: pop issued this cycle, FIFO word captured next cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight_v   <= 1'b0;
      inflight_src <= SRC_D0;
      prio         <= SRC_D0;
    end else begin
      inflight_v <= (state != IDLE);
      if (state != IDLE) begin
        inflight_src <= (state == SERVE_D1) ? SRC_D1 : SRC_D0;
        prio         <= (state == SERVE_D1) ? SRC_D0 : SRC_D1;
      end
    end
  end

  assign push_word = {logic'(inflight_src),
                      (inflight_src == SRC_D1) ? data_out_D1 : data_out_D0};

  egress_skid_fifo #(.WIDTH(DATA_WIDTH + 1)) u_buf (
    .clk       (clk),
    .reset     (reset),
    .push      (inflight_v),
    .push_data (push_word),
    .pop       (drain),
    .occ       (occ),
    .head      (head)
  );

  assign out_if.out_valid = (occ != 2'd0);
  assign out_if.out_data  = head[DATA_WIDTH-1:0];
  assign out_if.out_src   = src_t'(head[DATA_WIDTH]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_D0 <= '0;
      cnt_D1 <= '0;
    end else if (drain) begin
      if (out_if.out_src == SRC_D1) cnt_D1 <= sat_inc(cnt_D1);
      else                          cnt_D0 <= sat_inc(cnt_D0);
    end
  end

  assign idle_out = reset |
                    ((occ == 2'd0) & ~inflight_v & (~active_in | (empty_fifo_D0 & empty_fifo_D1)));

endmodule

// File: doc/d_egress_scheduler.md
# d_egress_scheduler

Downstream consumer of the two destination FIFOs (D0, D1) of the full_logic transmission block. Pops words from both FIFOs under round-robin arbitration, gated by the link-active status, and merges them into one tagged output stream with valid/ready backpressure. Keeps per-destination delivered-word counters and an idle flag for the next stage and the bench.

## Interface
- DATA_WIDTH, 6: word width, equal to the D0/D1 FIFO width.
- CNT_WIDTH, 8: width of the delivered-word counters.

Ports:
- clk  in  1  single clock domain, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- active_in  in  1  active_out of full_logic; new pops are allowed only while high.
- empty_fifo_D0, empty_fifo_D1  in  1 each  FIFO empty flags; registered; they reflect pops from prior cycles.
- data_out_D0, data_out_D1  in  DATA_WIDTH each  FIFO read data; a word is valid one cycle after its pop.
- D0_pop, D1_pop  out  1 each  FIFO read strobes; never both high in one cycle.
- out_valid  out  1  out_data/out_src hold a word.
- out_ready  in  1  downstream accepts the word when out_valid and out_ready are both high.
- out_data  out  DATA_WIDTH  merged word.
- out_src  out  1  source of the word: 0 = D0, 1 = D1.
- cnt_D0, cnt_D1  out  CNT_WIDTH each  words delivered per source; saturating.
- idle_out  out  1  high when nothing is buffered or in flight and no pop is possible.

## Operation
- Output buffer: 2-entry FIFO holding {src, data}, with occupancy occ (0..2).
- In-flight register: inflight_v and inflight_src record the pop issued last cycle. The word from data_out_D{src} is written into the buffer on the next edge.
- Drain: drain = out_valid & out_ready.
- Space condition: space = (occ + inflight_v - drain) < 2.
- A pop is eligible when active_in & space & at least one FIFO has its empty flag low.
- Arbitration uses a 1-bit priority pointer prio:
  - If both FIFOs are non-empty, pop the FIFO that prio points to, then toggle prio.
  - If only one FIFO is non-empty, pop it. Set prio to the other FIFO.
- Arbiter states:
  - IDLE: no pop this cycle.
  - SERVE_D0: D0_pop high.
  - SERVE_D1: D1_pop high.
  - The state is recomputed every cycle from the eligibility rule above; back-to-back pops are allowed.
- Falling edge of active_in: new pops stop immediately. The in-flight word and buffered words still drain normally.
- Simultaneous write and drain with occ = 2: the drain frees the head and the write is accepted. The space rule never allows an overflow.
- Counters: on drain, increment cnt_D{out_src}. At 2^CNT_WIDTH-1 the counter holds.
- idle_out = (occ == 0) & ~inflight_v & (~active_in | (empty_fifo_D0 & empty_fifo_D1)).
- Reset values: D0_pop = 0, D1_pop = 0, out_valid = 0, out_data = 0, out_src = 0, cnt_D0 = 0, cnt_D1 = 0, prio = 0 (D0 first), idle_out = 1.
- Reset mid-operation discards all buffered and in-flight words. The popped words are lost by design.

## Timing
- Pop-to-output latency is 2 cycles:
  - The pop is high in cycle t.
  - The FIFO data is valid in t+1 and captured at the end of t+1.
  - out_valid is high in t+2.
- With out_ready held high, throughput is 1 word per cycle.
- D*_pop depends combinationally on out_ready, through drain. out_valid, out_data and out_src are registered.
- out_data and out_src stay stable while out_valid & ~out_ready.

## Structure
- Shared package d_egress_pkg:
  - src_t enum: SRC_D0 = 0, SRC_D1 = 1.
  - arb_state_t: IDLE, SERVE_D0, SERVE_D1.
  - Constant BUF_DEPTH = 2.
- One sub-module, egress_skid_fifo: 2-entry, (1 + DATA_WIDTH) bits wide, with push, pop, occ, head outputs.
- The arbiter, in-flight register and counters live in the top module.

## Test plan
- Reset: assert reset mid-stream with occ = 2 -> all outputs reach their reset values asynchronously, both counters are 0, and the first pop after release goes to D0.
- Alternation: both FIFOs preloaded with 3 words each (D0: 6'b000101, D1: 6'b110110), active_in = 1, out_ready = 1 -> output sequence D0,D1,D0,D1,D0,D1. The first out_valid is 2 cycles after the first pop. cnt_D0 = cnt_D1 = 3.
- Single source: only D1 non-empty with 4 words of 6'b001110 -> 4 consecutive D1_pop pulses and D0_pop never high. out_src = 1 on every word.
- Backpressure: out_ready = 0 for 5 cycles while both FIFOs are full -> at most 2 pops issued, out_data stays stable, and no word is lost or duplicated once out_ready returns to 1.
- Link inactive: active_in drops the cycle after a pop -> no further pops, the in-flight word is still delivered, and idle_out rises once the buffer is empty.
- Saturation: with CNT_WIDTH = 2, deliver 6 D0 words -> cnt_D0 holds at 3.
